// File: rtl/memory_nport.sv
// Multi-channel word memory with round-robin request arbitration and a fixed-latency,
// in-order response pipeline that reports RISC-V misaligned and access faults.
module memory_nport #(
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS-1:0]      req_write,
  input  logic [NUM_PORTS*32-1:0]   req_addr,
  input  logic [NUM_PORTS*XLEN-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]      resp_valid,
  output logic [NUM_PORTS*XLEN-1:0] resp_data,
  output logic [NUM_PORTS-1:0]      resp_exception_valid,
  output logic [NUM_PORTS*4-1:0]    resp_exception
);
  localparam int BYTES = XLEN / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH * BYTES);

  logic [31:0]     w_addr  [NUM_PORTS];
  logic [XLEN-1:0] w_wdata [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[32*gi +: 32];
      assign w_wdata[gi] = req_wdata[XLEN*gi +: XLEN];
    end
  endgenerate

  logic [PW-1:0] r_prio;
  logic          w_gnt;
  logic [PW-1:0] w_gnt_idx;

  // First valid channel at or after the priority pointer, wrapping around.
  always_comb begin
    int c;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    c         = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      c = int'(r_prio) + k;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      if (!w_gnt && !reset && req_valid[c]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = PW'(c);
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign req_ready[gi] = w_gnt && (w_gnt_idx == PW'(gi));
    end
  endgenerate

  logic [31:0]     w_sel_addr;
  logic [XLEN-1:0] w_sel_wdata;
  logic            w_sel_write;
  logic [AW-1:0]   w_idx;
  logic            w_misal;
  logic            w_oob;
  logic            w_fault;
  logic [3:0]      w_code;

  assign w_sel_addr  = w_addr[w_gnt_idx];
  assign w_sel_wdata = w_wdata[w_gnt_idx];
  assign w_sel_write = req_write[w_gnt_idx];
  assign w_idx       = w_sel_addr[AW+OFF-1:OFF];
  assign w_misal     = |w_sel_addr[OFF-1:0];
  assign w_oob       = {1'b0, w_sel_addr} >= LIMIT;
  assign w_fault     = w_misal || w_oob;
  assign w_code      = w_misal ? (w_sel_write ? 4'd6 : 4'd4)
                               : (w_sel_write ? 4'd7 : 4'd5);

  // Storage is deliberately outside the reset domain so contents survive reset.
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (w_gnt && w_sel_write && !w_fault) r_mem[w_idx] <= w_sel_wdata;
    if (w_gnt) r_rdata <= r_mem[w_idx];
  end

  logic            r_vld  [LATENCY];
  logic [PW-1:0]   r_ch   [LATENCY];
  logic            r_exv  [LATENCY];
  logic [3:0]      r_code [LATENCY];
  logic            r_load [LATENCY];
  logic [XLEN-1:0] w_sdata[LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_vld[s]  <= 1'b0;
        r_ch[s]   <= '0;
        r_exv[s]  <= 1'b0;
        r_code[s] <= 4'd0;
        r_load[s] <= 1'b0;
      end
    end else begin
      if (w_gnt) r_prio <= (w_gnt_idx == PW'(NUM_PORTS-1)) ? '0 : w_gnt_idx + 1'b1;
      r_vld[0]  <= w_gnt;
      r_ch[0]   <= w_gnt_idx;
      r_exv[0]  <= w_gnt && w_fault;
      r_code[0] <= (w_gnt && w_fault) ? w_code : 4'd0;
      r_load[0] <= w_gnt && !w_sel_write && !w_fault;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_ch[s]   <= r_ch[s-1];
        r_exv[s]  <= r_exv[s-1];
        r_code[s] <= r_code[s-1];
        r_load[s] <= r_load[s-1];
      end
    end
  end

  // Read data needs no reset: it is only exposed alongside a valid load.
  assign w_sdata[0] = r_rdata;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_dpipe
      logic [XLEN-1:0] r_d;
      always_ff @(posedge clk) r_d <= w_sdata[gi-1];
      assign w_sdata[gi] = r_d;
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      logic w_hit;
      assign w_hit                    = r_vld[LATENCY-1] && (r_ch[LATENCY-1] == PW'(gi));
      assign resp_valid[gi]           = w_hit;
      assign resp_data[XLEN*gi +: XLEN] = (w_hit && r_load[LATENCY-1]) ? w_sdata[LATENCY-1] : '0;
      assign resp_exception_valid[gi] = w_hit && r_exv[LATENCY-1];
      assign resp_exception[4*gi +: 4] = w_hit ? r_code[LATENCY-1] : 4'd0;
    end
  endgenerate

endmodule

// File: tb/tb_memory_nport.sv
// Scoreboard bench for memory_nport: a 2-port/32-bit/latency-1 instance and a
// 4-port/64-bit/latency-3 instance driven with directed vectors.
module tb_memory_nport;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic        exv;
    logic [3:0]  code;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   a_cnt[2];

  // Instance A: NUM_PORTS=2, XLEN=32, DEPTH=1024, LATENCY=1
  logic        a_rst;
  logic [1:0]  a_valid, a_ready, a_write, a_rvalid, a_exv;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic [7:0]  a_exc;

  memory_nport #(.NUM_PORTS(2), .XLEN(32), .DEPTH(1024), .LATENCY(1)) u_a (
    .clk(clk), .reset(a_rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rvalid), .resp_data(a_rdata),
    .resp_exception_valid(a_exv), .resp_exception(a_exc)
  );

  // Instance B: NUM_PORTS=4, XLEN=64, DEPTH=64, LATENCY=3
  logic         b_rst;
  logic [3:0]   b_valid, b_ready, b_write, b_rvalid, b_exv;
  logic [127:0] b_addr;
  logic [255:0] b_wdata, b_rdata;
  logic [15:0]  b_exc;

  memory_nport #(.NUM_PORTS(4), .XLEN(64), .DEPTH(64), .LATENCY(3)) u_b (
    .clk(clk), .reset(b_rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rvalid), .resp_data(b_rdata),
    .resp_exception_valid(b_exv), .resp_exception(b_exc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step_a(input int g, input logic [63:0] d, input logic ev, input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    chk("a_ready", 64'(a_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      e.ch = g; e.data = d; e.exv = ev; e.code = c; e.due = cyc + 1;
      qa.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input int g, input logic [63:0] d, input logic ev, input logic [3:0] c,
                        input bit push);
    exp_t e;
    @(negedge clk);
    chk("b_ready", 64'(b_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0 && push) begin
      e.ch = g; e.data = d; e.exv = ev; e.code = c; e.due = cyc + 3;
      qb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic bad;
    if (!a_rst) begin
      while (qa.size() > 0 && qa[0].due < cyc) begin
        n_checks++;
        $display("FAIL a_missing_resp: ch%0d due cycle %0d never answered", qa[0].ch, qa[0].due);
        void'(qa.pop_front());
      end
      bad = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        if (a_rvalid[ch]) begin
          if (qa.size() == 0) begin
            n_checks++;
            $display("FAIL a_unexpected_resp: ch%0d at cycle %0d, none expected", ch, cyc);
          end else begin
            e = qa.pop_front();
            chk("a_resp_ch",   64'(ch), 64'(e.ch));
            chk("a_resp_time", 64'(cyc), 64'(e.due));
            chk("a_resp_data", 64'(a_rdata[ch*32 +: 32]), e.data);
            chk("a_resp_exv",  64'(a_exv[ch]), 64'(e.exv));
            chk("a_resp_code", 64'(a_exc[ch*4 +: 4]), 64'(e.code));
            a_cnt[ch]++;
            $display("A resp ch%0d data=0x%0h exv=%0d code=%0d cycle=%0d",
                     ch, a_rdata[ch*32 +: 32], a_exv[ch], a_exc[ch*4 +: 4], cyc);
          end
        end else if (a_rdata[ch*32 +: 32] != 0 || a_exv[ch] || a_exc[ch*4 +: 4] != 0) begin
          bad = 1'b1;
        end
      end
      chk("a_idle_zero", 64'(bad), 64'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic bad;
    if (!b_rst) begin
      while (qb.size() > 0 && qb[0].due < cyc) begin
        n_checks++;
        $display("FAIL b_missing_resp: ch%0d due cycle %0d never answered", qb[0].ch, qb[0].due);
        void'(qb.pop_front());
      end
      bad = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        if (b_rvalid[ch]) begin
          if (qb.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected_resp: ch%0d at cycle %0d, none expected", ch, cyc);
          end else begin
            e = qb.pop_front();
            chk("b_resp_ch",   64'(ch), 64'(e.ch));
            chk("b_resp_time", 64'(cyc), 64'(e.due));
            chk("b_resp_data", b_rdata[ch*64 +: 64], e.data);
            chk("b_resp_exv",  64'(b_exv[ch]), 64'(e.exv));
            chk("b_resp_code", 64'(b_exc[ch*4 +: 4]), 64'(e.code));
            $display("B resp ch%0d data=0x%0h exv=%0d code=%0d cycle=%0d",
                     ch, b_rdata[ch*64 +: 64], b_exv[ch], b_exc[ch*4 +: 4], cyc);
          end
        end else if (b_rdata[ch*64 +: 64] != 0 || b_exv[ch] || b_exc[ch*4 +: 4] != 0) begin
          bad = 1'b1;
        end
      end
      chk("b_idle_zero", 64'(bad), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    a_cnt[0] = 0; a_cnt[1] = 0;
    a_rst = 1'b1; a_valid = 2'b11; a_write = 2'b00; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_valid = 4'hF;  b_write = 4'h0;  b_addr = '0; b_wdata = '0;

    // Reset state with every channel requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_rst_outs", 64'({a_ready, a_rvalid, a_exv, a_exc, |a_rdata}), 64'd0);
    chk("b_rst_outs", 64'({b_ready, b_rvalid, b_exv, b_exc, |b_rdata}), 64'd0);
    @(posedge clk); #1;
    a_rst = 1'b0; a_valid = 2'b00;
    b_rst = 1'b0; b_valid = 4'h0;

    // A: store then back-to-back load on ch1.
    a_valid = 2'b10; a_write = 2'b10;
    a_addr[63:32] = 32'h10; a_wdata[63:32] = 32'hDEADBEEF;
    step_a(1, 64'd0, 1'b0, 4'd0);
    a_write = 2'b00;
    step_a(1, 64'hDEADBEEF, 1'b0, 4'd0);
    a_valid = 2'b00;
    step_a(-1, 64'd0, 1'b0, 4'd0);

    // A: both channels storing for 6 cycles, grants alternate 0,1,...
    c0 = a_cnt[0]; c1 = a_cnt[1];
    a_valid = 2'b11; a_write = 2'b11;
    for (int i = 0; i < 6; i++) begin
      a_addr  = {32'h200 + 32'(4*i), 32'h100 + 32'(4*i)};
      a_wdata = {32'h2000 + 32'(i), 32'h1000 + 32'(i)};
      step_a(i % 2, 64'd0, 1'b0, 4'd0);
    end
    a_valid = 2'b00;
    step_a(-1, 64'd0, 1'b0, 4'd0);
    chk("a_ch0_resp_count", 64'(a_cnt[0] - c0), 64'd3);
    chk("a_ch1_resp_count", 64'(a_cnt[1] - c1), 64'd3);

    // A: fault codes on ch0; faulting stores alias words 4 and 0 but must not write.
    a_valid = 2'b01;
    a_write = 2'b01; a_addr[31:0] = 32'h0;    a_wdata[31:0] = 32'hCAFEF00D; step_a(0, 64'd0, 1'b0, 4'd0);
    a_write = 2'b00; a_addr[31:0] = 32'h13;                                 step_a(0, 64'd0, 1'b1, 4'd4);
    a_write = 2'b01; a_addr[31:0] = 32'h13;   a_wdata[31:0] = 32'h77;       step_a(0, 64'd0, 1'b1, 4'd6);
    a_write = 2'b00; a_addr[31:0] = 32'h1000;                               step_a(0, 64'd0, 1'b1, 4'd5);
    a_write = 2'b01; a_addr[31:0] = 32'h1000; a_wdata[31:0] = 32'h55;       step_a(0, 64'd0, 1'b1, 4'd7);
    a_write = 2'b00; a_addr[31:0] = 32'h0;                                  step_a(0, 64'hCAFEF00D, 1'b0, 4'd0);
    a_write = 2'b00; a_addr[31:0] = 32'h10;                                 step_a(0, 64'hDEADBEEF, 1'b0, 4'd0);
    a_write = 2'b01; a_addr[31:0] = 32'hFFC;  a_wdata[31:0] = 32'h0BADCAFE; step_a(0, 64'd0, 1'b0, 4'd0);
    a_write = 2'b00; a_addr[31:0] = 32'hFFC;                                step_a(0, 64'h0BADCAFE, 1'b0, 4'd0);

    // A: pointer now at ch1, so ch1 wins first, then ch0.
    a_valid = 2'b11; a_write = 2'b00;
    a_addr = {32'h214, 32'h108};
    step_a(1, 64'h2005, 1'b0, 4'd0);
    step_a(0, 64'h1002, 1'b0, 4'd0);
    a_valid = 2'b00;
    repeat (2) step_a(-1, 64'd0, 1'b0, 4'd0);

    // B: only ch2 and ch3 storing, grants alternate 2,3.
    b_valid = 4'b1100; b_write = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      b_addr[64 +: 32]  = 32'h40 + 32'(8*i);
      b_addr[96 +: 32]  = 32'h80 + 32'(8*i);
      b_wdata[128 +: 64] = 64'hA0 + 64'(i);
      b_wdata[192 +: 64] = 64'hB0 + 64'(i);
      step_b((i % 2 == 0) ? 2 : 3, 64'd0, 1'b0, 4'd0, 1'b1);
    end

    // B: 8-byte alignment uses addr[2:0]; out-of-range load.
    b_valid = 4'b0100; b_write = 4'b0000;
    b_addr[64 +: 32] = 32'h44;  step_b(2, 64'd0, 1'b1, 4'd4, 1'b1);
    b_addr[64 +: 32] = 32'h200; step_b(2, 64'd0, 1'b1, 4'd5, 1'b1);

    // B: four loads on consecutive cycles, pointer starts at ch3.
    b_valid = 4'b1100;
    b_addr[96 +: 32] = 32'h88; b_addr[64 +: 32] = 32'h40; step_b(3, 64'hB1, 1'b0, 4'd0, 1'b1);
    b_addr[96 +: 32] = 32'h98;                            step_b(2, 64'hA0, 1'b0, 4'd0, 1'b1);
    b_addr[64 +: 32] = 32'h50;                            step_b(3, 64'hB3, 1'b0, 4'd0, 1'b1);
    b_valid = 4'b0100;                                    step_b(2, 64'hA2, 1'b0, 4'd0, 1'b1);
    b_valid = 4'b0000;
    repeat (4) step_b(-1, 64'd0, 1'b0, 4'd0, 1'b0);

    // B: reset one cycle after a load grant drops that load; storage survives.
    b_valid = 4'b0010; b_write = 4'b0010;
    b_addr[32 +: 32] = 32'h100; b_wdata[64 +: 64] = 64'h1122334455667788;
    step_b(1, 64'd0, 1'b0, 4'd0, 1'b1);
    b_valid = 4'b0000;
    repeat (4) step_b(-1, 64'd0, 1'b0, 4'd0, 1'b0);
    b_valid = 4'b0010; b_write = 4'b0000;
    step_b(1, 64'd0, 1'b0, 4'd0, 1'b0);
    b_rst = 1'b1; b_valid = 4'hF;
    @(negedge clk);
    chk("b_rst_mid_outs", 64'({b_ready, b_rvalid, b_exv, b_exc, |b_rdata}), 64'd0);
    @(posedge clk); #1;
    b_rst = 1'b0; b_valid = 4'b0010;
    step_b(1, 64'h1122334455667788, 1'b0, 4'd0, 1'b1);
    b_valid = 4'b0000;
    repeat (6) step_b(-1, 64'd0, 1'b0, 4'd0, 1'b0);

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
